// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD init/fill sequencer.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_SEND = 3'd0,
    ST_INIT_WAIT = 3'd1,
    ST_IDLE      = 3'd2,
    ST_WIN       = 3'd3,
    ST_PIX_HI    = 3'd4,
    ST_PIX_LO    = 3'd5
  } state_e;

  localparam logic [7:0] CASET   = 8'h2A;
  localparam logic [7:0] RASET   = 8'h2B;
  localparam logic [7:0] RAMWR   = 8'h2C;
  localparam logic [7:0] SWRESET = 8'h01;
  localparam logic [7:0] SLPOUT  = 8'h11;
  localparam logic [7:0] COLMOD  = 8'h3A;
  localparam logic [7:0] DISPON  = 8'h29;

  localparam int         INIT_LEN = 5;
  localparam logic [3:0] WIN_LAST = 4'd10;

  typedef struct packed {
    logic [7:0] data;
    logic       mode;
    logic       delay;
  } init_entry_t;

  typedef struct packed {
    logic [7:0] data;
    logic       mode;
  } spi_byte_t;

  typedef struct packed {
    logic [7:0]  x0;
    logic [7:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  y1;
    logic [15:0] color;
  } fill_t;

  // Address-window preamble: CASET x0..x1, RASET y0..y1, then RAMWR.
  function automatic spi_byte_t win_byte(input logic [3:0] idx, input fill_t f);
    spi_byte_t b;
    b = '{data: 8'h00, mode: 1'b1};
    case (idx)
      4'd0:    b = '{data: CASET, mode: 1'b0};
      4'd2:    b.data = f.x0;
      4'd4:    b.data = f.x1;
      4'd5:    b = '{data: RASET, mode: 1'b0};
      4'd7:    b.data = f.y0;
      4'd9:    b.data = f.y1;
      4'd10:   b = '{data: RAMWR, mode: 1'b0};
      default: b = '{data: 8'h00, mode: 1'b1};
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Panel power-up command table, one entry per index.
module lcd_init_rom
  import lcd_pkg::*;
(
  input  logic [2:0]  idx_i,
  output init_entry_t entry_o
);

  always_comb begin
    entry_o = '{data: 8'h00, mode: 1'b0, delay: 1'b0};
    case (idx_i)
      3'd0:    entry_o = '{data: SWRESET, mode: 1'b0, delay: 1'b1};
      3'd1:    entry_o = '{data: SLPOUT,  mode: 1'b0, delay: 1'b1};
      3'd2:    entry_o = '{data: COLMOD,  mode: 1'b0, delay: 1'b0};
      3'd3:    entry_o = '{data: 8'h55,   mode: 1'b1, delay: 1'b0};
      3'd4:    entry_o = '{data: DISPON,  mode: 1'b0, delay: 1'b0};
      default: entry_o = '{data: 8'h00,   mode: 1'b0, delay: 1'b0};
    endcase
  end

endmodule

// File: rtl/lcd_seq.sv
// LCD sequencer: runs the panel init table, then fills rectangles with a
// solid RGB565 colour via a valid/ready byte stream to the SPI block.
module lcd_seq
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_DELAY_CYC = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x0,
  input  logic [7:0]  req_y0,
  input  logic [7:0]  req_w,
  input  logic [7:0]  req_h,
  input  logic [15:0] req_color,
  output logic        spi_valid,
  input  logic        spi_ready,
  output logic [7:0]  spi_cmd,
  output logic        spi_mode,
  output logic        init_done
);

  localparam int CNT_W = (INIT_DELAY_CYC > 1) ? $clog2(INIT_DELAY_CYC) : 1;

  state_e           state_q,   state_d;
  logic [2:0]       rom_idx_q, rom_idx_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]       win_idx_q, win_idx_d;
  logic [15:0]      pix_cnt_q, pix_cnt_d;
  fill_t            fill_q,    fill_d;
  logic             valid_q,   valid_d;
  logic             done_q,    done_d;

  init_entry_t rom_entry;
  spi_byte_t   cur_byte;

  lcd_init_rom u_rom (
    .idx_i   (rom_idx_q),
    .entry_o (rom_entry)
  );

  always_comb begin
    cur_byte = '{data: 8'h00, mode: 1'b0};
    case (state_q)
      ST_INIT_SEND: cur_byte = '{data: rom_entry.data, mode: rom_entry.mode};
      ST_WIN:       cur_byte = win_byte(win_idx_q, fill_q);
      ST_PIX_HI:    cur_byte = '{data: fill_q.color[15:8], mode: 1'b1};
      ST_PIX_LO:    cur_byte = '{data: fill_q.color[7:0],  mode: 1'b1};
      default:      cur_byte = '{data: 8'h00, mode: 1'b0};
    endcase
  end

  // The byte is a pure function of registered state, so it cannot move while stalled.
  assign spi_valid = valid_q;
  assign spi_cmd   = valid_q ? cur_byte.data : 8'h00;
  assign spi_mode  = valid_q & cur_byte.mode;
  assign req_ready = (state_q == ST_IDLE);
  assign init_done = done_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    state_d    = state_q;
    rom_idx_d  = rom_idx_q;
    wait_cnt_d = wait_cnt_q;
    win_idx_d  = win_idx_q;
    pix_cnt_d  = pix_cnt_q;
    fill_d     = fill_q;
    valid_d    = valid_q;
    done_d     = done_q;

    case (state_q)
      ST_INIT_SEND: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (spi_ready) begin
          if (rom_entry.delay) begin
            state_d    = ST_INIT_WAIT;
            valid_d    = 1'b0;
            wait_cnt_d = '0;
            rom_idx_d  = rom_idx_q + 3'd1;
          end else if (rom_idx_q == 3'(INIT_LEN - 1)) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            rom_idx_d = rom_idx_q + 3'd1;
          end
        end
      end
      ST_INIT_WAIT: begin
        // Raise valid on the last wait cycle so the gap is exactly INIT_DELAY_CYC.
        if (wait_cnt_q == CNT_W'(INIT_DELAY_CYC - 1)) begin
          state_d = ST_INIT_SEND;
          valid_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          fill_d.x0    = req_x0;
          fill_d.x1    = req_x0 + req_w - 8'd1;
          fill_d.y0    = req_y0;
          fill_d.y1    = req_y0 + req_h - 8'd1;
          fill_d.color = req_color;
          pix_cnt_d    = 16'(req_w) * 16'(req_h);
          win_idx_d    = 4'd0;
          state_d      = ST_WIN;
        end
      end
      ST_WIN: begin
        if (!valid_q) begin
          if (pix_cnt_q == 16'd0) state_d = ST_IDLE;
          else                    valid_d = 1'b1;
        end else if (spi_ready) begin
          if (win_idx_q == WIN_LAST) state_d   = ST_PIX_HI;
          else                       win_idx_d = win_idx_q + 4'd1;
        end
      end
      ST_PIX_HI: begin
        if (spi_ready) state_d = ST_PIX_LO;
      end
      ST_PIX_LO: begin
        if (spi_ready) begin
          pix_cnt_d = pix_cnt_q - 16'd1;
          if (pix_cnt_q == 16'd1) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = ST_PIX_HI;
          end
        end
      end
      default: state_d = ST_INIT_SEND;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst) begin
      state_q    <= ST_INIT_SEND;
      rom_idx_q  <= '0;
      wait_cnt_q <= '0;
      win_idx_q  <= '0;
      pix_cnt_q  <= '0;
      fill_q     <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rom_idx_q  <= rom_idx_d;
      wait_cnt_q <= wait_cnt_d;
      win_idx_q  <= win_idx_d;
      pix_cnt_q  <= pix_cnt_d;
      fill_q     <= fill_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
    end
  end

endmodule
